// File: rtl/lb_arb2.sv
// ---------------------------------------------------------------------------
// lb_arb2 -- two-master arbiter for the 32-bit local bus.
//
// Master 0 (Mesa-bus bridge) and master 1 (on-chip requester) each issue
// single-cycle write/read strobes with no backpressure. Every strobe is held
// in a one-entry slot per master, the bus is granted round-robin, exactly
// one transaction is in flight at a time, and read data (or TIMEOUT_DATA on
// a slave timeout) is steered back to the master that issued the read.
//
// Parameters:
//   TIMEOUT       cycles to wait for i_lb_rd_rdy after o_lb_rd (1..65535)
//   TIMEOUT_DATA  read data returned when the slave never answers
//
// Ports:
//   i_clk_lb                 single clock, rising edge
//   i_reset_l                synchronous active-low reset
//   i_mN_wr / i_mN_rd        single-cycle write / read strobes, N = 0,1
//   i_mN_addr / i_mN_wr_d    address and write data sampled with the strobe
//   o_mN_rd_d / o_mN_rd_rdy  read return data and its one-cycle valid pulse
//   o_mN_busy                master N has a held or in-flight transaction
//   o_mN_err                 sticky: dropped strobe or read timeout
//   o_lb_wr / o_lb_rd        registered single-cycle strobes to the slave
//   o_lb_addr / o_lb_wr_d    registered address / write data to the slave
//   i_lb_rd_d / i_lb_rd_rdy  slave read data and read-data-valid pulse
// ---------------------------------------------------------------------------
module lb_arb2 #(
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        i_clk_lb,
    input  logic        i_reset_l,
    input  logic        i_m0_wr,
    input  logic        i_m0_rd,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wr_d,
    input  logic        i_m1_wr,
    input  logic        i_m1_rd,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wr_d,
    output logic [31:0] o_m0_rd_d,
    output logic [31:0] o_m1_rd_d,
    output logic        o_m0_rd_rdy,
    output logic        o_m1_rd_rdy,
    output logic        o_m0_busy,
    output logic        o_m1_busy,
    output logic        o_m0_err,
    output logic        o_m1_err,
    output logic        o_lb_wr,
    output logic        o_lb_rd,
    output logic [31:0] o_lb_addr,
    output logic [31:0] o_lb_wr_d,
    input  logic [31:0] i_lb_rd_d,
    input  logic        i_lb_rd_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RD_WAIT
    } state_t;

    // Per-master views of the request ports, indexed by master number.
    logic [1:0]  w_wr;
    logic [1:0]  w_rd;
    logic [31:0] w_addr [2];
    logic [31:0] w_wrD  [2];

    assign w_wr      = {i_m1_wr, i_m0_wr};
    assign w_rd      = {i_m1_rd, i_m0_rd};
    assign w_addr[0] = i_m0_addr;
    assign w_addr[1] = i_m1_addr;
    assign w_wrD[0]  = i_m0_wr_d;
    assign w_wrD[1]  = i_m1_wr_d;

    // Holding slots: r_opRd is 1 for a read, 0 for a write.
    logic [1:0]  r_pend;
    logic [1:0]  r_opRd;
    logic [31:0] r_hAddr [2];
    logic [31:0] r_hData [2];
    logic [1:0]  r_err;

    // Arbitration / transaction state.
    state_t      r_state;
    state_t      w_stateNext;
    logic        r_owner;
    logic        w_ownerNext;
    logic        r_last;
    logic        w_lastNext;
    logic        w_winner;
    logic [15:0] r_cnt;
    logic [15:0] w_cntNext;
    logic [15:0] w_cntInc;

    // Registered outputs and their next values.
    logic        r_lbWr;
    logic        w_lbWrNext;
    logic        r_lbRd;
    logic        w_lbRdNext;
    logic [31:0] r_lbAddr;
    logic [31:0] w_lbAddrNext;
    logic [31:0] r_lbWrD;
    logic [31:0] w_lbWrDNext;
    logic [1:0]  r_rdRdy;
    logic [1:0]  w_rdRdyNext;
    logic [31:0] r_rdD     [2];
    logic [31:0] w_rdDNext [2];

    logic [1:0]  w_slotFree;
    logic [1:0]  w_accept;
    logic [1:0]  w_drop;
    logic [1:0]  w_clrPend;
    logic [1:0]  w_tmoErr;

    // Slot acceptance. A slot counts as free in the very cycle its entry is
    // being issued (WR or RD state), so a master can re-strobe immediately.
    // While the master's own read is waiting for data the slot is locked.
    // A write+read pair keeps the write and flags the lost read.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_slotFree[n] = (!r_pend[n]
                             || (((r_state == S_WR) || (r_state == S_RD)) && (r_owner == 1'(n))))
                            && !((r_state == S_RD_WAIT) && (r_owner == 1'(n)));
            w_accept[n]   = (w_wr[n] || w_rd[n]) && w_slotFree[n];
            w_drop[n]     = ((w_wr[n] || w_rd[n]) && !w_slotFree[n]) || (w_wr[n] && w_rd[n]);
        end
    end

    // Holding slots and sticky error flags. A fresh capture wins over the
    // retire-clear of the same slot.
    always_ff @(posedge i_clk_lb) begin
        if (!i_reset_l) begin
            r_pend <= 2'b00;
            r_opRd <= 2'b00;
            r_err  <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_hAddr[n] <= 32'h0;
                r_hData[n] <= 32'h0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_accept[n]) begin
                    r_pend[n]  <= 1'b1;
                    r_opRd[n]  <= !w_wr[n];
                    r_hAddr[n] <= w_addr[n];
                    r_hData[n] <= w_wrD[n];
                end else if (w_clrPend[n]) begin
                    r_pend[n] <= 1'b0;
                end
            end
            r_err <= r_err | w_drop | w_tmoErr;
        end
    end

    // Round-robin pick: on a tie the master not granted last time wins.
    assign w_winner = (r_pend == 2'b11) ? ~r_last : r_pend[1];

    // Saturating timeout counter increment.
    assign w_cntInc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // Next-state and registered-output logic. The timeout fires in the cycle
    // the incremented count reaches TIMEOUT so that the return pulse lands
    // TIMEOUT+1 cycles after the lb_rd cycle.
    always_comb begin
        w_stateNext  = r_state;
        w_ownerNext  = r_owner;
        w_lastNext   = r_last;
        w_cntNext    = r_cnt;
        w_lbWrNext   = 1'b0;
        w_lbRdNext   = 1'b0;
        w_lbAddrNext = r_lbAddr;
        w_lbWrDNext  = r_lbWrD;
        w_rdRdyNext  = 2'b00;
        w_rdDNext[0] = r_rdD[0];
        w_rdDNext[1] = r_rdD[1];
        w_clrPend    = 2'b00;
        w_tmoErr     = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_ownerNext  = w_winner;
                    w_lastNext   = w_winner;
                    w_lbAddrNext = r_hAddr[w_winner];
                    if (r_opRd[w_winner]) begin
                        w_stateNext = S_RD;
                        w_lbRdNext  = 1'b1;
                    end else begin
                        w_stateNext = S_WR;
                        w_lbWrNext  = 1'b1;
                        w_lbWrDNext = r_hData[w_winner];
                    end
                end
            end
            S_WR: begin
                w_clrPend[r_owner] = 1'b1;
                w_stateNext        = S_IDLE;
            end
            S_RD: begin
                w_clrPend[r_owner] = 1'b1;
                w_cntNext          = 16'd0;
                w_stateNext        = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_lb_rd_rdy) begin
                    w_rdDNext[r_owner]   = i_lb_rd_d;
                    w_rdRdyNext[r_owner] = 1'b1;
                    w_stateNext          = S_IDLE;
                end else if ({16'h0, w_cntInc} >= TIMEOUT) begin
                    w_rdDNext[r_owner]   = TIMEOUT_DATA;
                    w_rdRdyNext[r_owner] = 1'b1;
                    w_tmoErr[r_owner]    = 1'b1;
                    w_stateNext          = S_IDLE;
                end else begin
                    w_cntNext = w_cntInc;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any read silently.
    always_ff @(posedge i_clk_lb) begin
        if (!i_reset_l) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_cnt    <= 16'd0;
            r_lbWr   <= 1'b0;
            r_lbRd   <= 1'b0;
            r_lbAddr <= 32'h0;
            r_lbWrD  <= 32'h0;
            r_rdRdy  <= 2'b00;
            r_rdD[0] <= 32'h0;
            r_rdD[1] <= 32'h0;
        end else begin
            r_state  <= w_stateNext;
            r_owner  <= w_ownerNext;
            r_last   <= w_lastNext;
            r_cnt    <= w_cntNext;
            r_lbWr   <= w_lbWrNext;
            r_lbRd   <= w_lbRdNext;
            r_lbAddr <= w_lbAddrNext;
            r_lbWrD  <= w_lbWrDNext;
            r_rdRdy  <= w_rdRdyNext;
            r_rdD[0] <= w_rdDNext[0];
            r_rdD[1] <= w_rdDNext[1];
        end
    end

    assign o_lb_wr     = r_lbWr;
    assign o_lb_rd     = r_lbRd;
    assign o_lb_addr   = r_lbAddr;
    assign o_lb_wr_d   = r_lbWrD;
    assign o_m0_rd_rdy = r_rdRdy[0];
    assign o_m1_rd_rdy = r_rdRdy[1];
    assign o_m0_rd_d   = r_rdD[0];
    assign o_m1_rd_d   = r_rdD[1];
    assign o_m0_err    = r_err[0];
    assign o_m1_err    = r_err[1];

    // Busy covers the held entry plus ownership of the active transaction.
    assign o_m0_busy   = r_pend[0] || ((r_state != S_IDLE) && !r_owner);
    assign o_m1_busy   = r_pend[1] || ((r_state != S_IDLE) && r_owner);

endmodule

// File: tb/tb_lb_arb2.sv
// ---------------------------------------------------------------------------
// tb_lb_arb2 -- self-checking bench for lb_arb2 (TIMEOUT = 8).
// A cycle table covers single write, dropped strobes and simultaneous reads;
// hand-written sequences cover timeout, reset during a read and fairness.
// ---------------------------------------------------------------------------
module tb_lb_arb2;

    logic        clock = 1'b0;
    logic        resetL;
    logic        m0Wr, m0Rd, m1Wr, m1Rd;
    logic [31:0] m0Addr, m0WrD, m1Addr, m1WrD;
    logic [31:0] m0RdD, m1RdD;
    logic        m0RdRdy, m1RdRdy, m0Busy, m1Busy, m0Err, m1Err;
    logic        lbWr, lbRd;
    logic [31:0] lbAddr, lbWrD, lbRdD;
    logic        lbRdRdy;

    int checks = 0;
    int errors = 0;

    // One table row: inputs for a cycle plus the outputs expected in it.
    // eStat = {lb_wr, lb_rd, m1_busy, m0_busy, m1_err, m0_err, m1_rd_rdy, m0_rd_rdy}
    // strb  = {m1_rd, m1_wr, m0_rd, m0_wr}
    typedef struct {
        logic        rstL;
        logic [3:0]  strb;
        logic [31:0] m0Addr;
        logic [31:0] m0D;
        logic [31:0] m1Addr;
        logic        lbRdy;
        logic [31:0] lbRdD;
        logic [7:0]  eStat;
        logic [31:0] eAddr;
        logic [31:0] eWrD;
        logic [31:0] eRd0;
        logic [31:0] eRd1;
    } vec_t;

    localparam int NVEC = 24;
    localparam logic [31:0] Z = 32'h0;
    vec_t vecs [NVEC];

    // Clock generation.
    always #5 clock = ~clock;

    lb_arb2 #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .i_clk_lb    (clock),
        .i_reset_l   (resetL),
        .i_m0_wr     (m0Wr),
        .i_m0_rd     (m0Rd),
        .i_m0_addr   (m0Addr),
        .i_m0_wr_d   (m0WrD),
        .i_m1_wr     (m1Wr),
        .i_m1_rd     (m1Rd),
        .i_m1_addr   (m1Addr),
        .i_m1_wr_d   (m1WrD),
        .o_m0_rd_d   (m0RdD),
        .o_m1_rd_d   (m1RdD),
        .o_m0_rd_rdy (m0RdRdy),
        .o_m1_rd_rdy (m1RdRdy),
        .o_m0_busy   (m0Busy),
        .o_m1_busy   (m1Busy),
        .o_m0_err    (m0Err),
        .o_m1_err    (m1Err),
        .o_lb_wr     (lbWr),
        .o_lb_rd     (lbRd),
        .o_lb_addr   (lbAddr),
        .o_lb_wr_d   (lbWrD),
        .i_lb_rd_d   (lbRdD),
        .i_lb_rd_rdy (lbRdRdy)
    );

    function automatic vec_t mk(input logic rstL, input logic [3:0] strb,
                                input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic rdy,
                                input logic [31:0] rdD, input logic [7:0] st,
                                input logic [31:0] ea, input logic [31:0] ew,
                                input logic [31:0] r0, input logic [31:0] r1);
        vec_t v;
        v.rstL = rstL;  v.strb = strb;  v.m0Addr = a0; v.m0D = d0;
        v.m1Addr = a1;  v.lbRdy = rdy;  v.lbRdD = rdD; v.eStat = st;
        v.eAddr = ea;   v.eWrD = ew;    v.eRd0 = r0;   v.eRd1 = r1;
        return v;
    endfunction

    function automatic logic [7:0] status();
        return {lbWr, lbRd, m1Busy, m0Busy, m1Err, m0Err, m1RdRdy, m0RdRdy};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        resetL  = v.rstL;
        m0Wr    = v.strb[0];
        m0Rd    = v.strb[1];
        m1Wr    = v.strb[2];
        m1Rd    = v.strb[3];
        m0Addr  = v.m0Addr;
        m0WrD   = v.m0D;
        m1Addr  = v.m1Addr;
        m1WrD   = 32'h0;
        lbRdRdy = v.lbRdy;
        lbRdD   = v.lbRdD;
    endtask

    task automatic idleInputs();
        resetL = 1'b1; m0Wr = 1'b0; m0Rd = 1'b0; m1Wr = 1'b0; m1Rd = 1'b0;
        lbRdRdy = 1'b0; lbRdD = 32'h0;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        int n;
        int k;
        int grants;
        int cyc;
        int a0;
        int a1;
        logic prevBusy0;
        logic prevBusy1;
        logic wr0;
        logic wr1;

        // Cycle table; row index is the cycle after reset release.
        vecs[0]  = mk(1'b1, 4'b0001, 32'h10, 32'h12345678, Z, 1'b0, Z, 8'b00_00_00_00, Z, Z, Z, Z);
        vecs[1]  = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_01_00_00, Z, Z, Z, Z);
        vecs[2]  = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b10_01_00_00, 32'h10, 32'h12345678, Z, Z);
        vecs[3]  = mk(1'b1, 4'b0001, 32'h20, 32'h11111111, Z, 1'b0, Z, 8'b00_00_00_00, 32'h10, 32'h12345678, Z, Z);
        vecs[4]  = mk(1'b1, 4'b0001, 32'h30, 32'h22222222, Z, 1'b0, Z, 8'b00_01_00_00, 32'h10, 32'h12345678, Z, Z);
        vecs[5]  = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b10_01_01_00, 32'h20, 32'h11111111, Z, Z);
        vecs[6]  = mk(1'b0, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_00_01_00, 32'h20, 32'h11111111, Z, Z);
        vecs[7]  = mk(1'b1, 4'b0011, 32'h40, 32'h33333333, Z, 1'b0, Z, 8'b00_00_00_00, Z, Z, Z, Z);
        vecs[8]  = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_01_01_00, Z, Z, Z, Z);
        vecs[9]  = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b10_01_01_00, 32'h40, 32'h33333333, Z, Z);
        vecs[10] = mk(1'b0, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_00_01_00, 32'h40, 32'h33333333, Z, Z);
        vecs[11] = mk(1'b1, 4'b1010, 32'h4, Z, 32'h8, 1'b0, Z, 8'b00_00_00_00, Z, Z, Z, Z);
        vecs[12] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_11_00_00, Z, Z, Z, Z);
        vecs[13] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b01_11_00_00, 32'h4, Z, Z, Z);
        vecs[14] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_11_00_00, 32'h4, Z, Z, Z);
        vecs[15] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_11_00_00, 32'h4, Z, Z, Z);
        vecs[16] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b1, 32'hA5A5A5A5, 8'b00_11_00_00, 32'h4, Z, Z, Z);
        vecs[17] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_10_00_01, 32'h4, Z, 32'hA5A5A5A5, Z);
        vecs[18] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b01_10_00_00, 32'h8, Z, 32'hA5A5A5A5, Z);
        vecs[19] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_10_00_00, 32'h8, Z, 32'hA5A5A5A5, Z);
        vecs[20] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_10_00_00, 32'h8, Z, 32'hA5A5A5A5, Z);
        vecs[21] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b1, 32'h5A5A5A5A, 8'b00_10_00_00, 32'h8, Z, 32'hA5A5A5A5, Z);
        vecs[22] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_00_00_10, 32'h8, Z, 32'hA5A5A5A5, 32'h5A5A5A5A);
        vecs[23] = mk(1'b1, 4'b0000, Z, Z, Z, 1'b0, Z, 8'b00_00_00_00, 32'h8, Z, 32'hA5A5A5A5, 32'h5A5A5A5A);

        // Reset preamble.
        applyStimulus(mk(1'b0, 4'b0000, Z, Z, Z, 1'b0, Z, 8'h0, Z, Z, Z, Z));
        m1WrD = 32'h0;
        repeat (3) tick();

        // Table-driven part.
        for (int i = 0; i < NVEC; i++) begin
            checkOutput($sformatf("row%0d status", i), 32'(status()), 32'(vecs[i].eStat));
            checkOutput($sformatf("row%0d lb_addr", i), lbAddr, vecs[i].eAddr);
            checkOutput($sformatf("row%0d lb_wr_d", i), lbWrD, vecs[i].eWrD);
            checkOutput($sformatf("row%0d m0_rd_d", i), m0RdD, vecs[i].eRd0);
            checkOutput($sformatf("row%0d m1_rd_d", i), m1RdD, vecs[i].eRd1);
            applyStimulus(vecs[i]);
            tick();
        end

        // Timeout: slave never answers a master-1 read.
        idleInputs();
        m1Rd = 1'b1; m1Addr = 32'hC;
        tick();
        m1Rd = 1'b0;
        n = 0;
        while (!lbRd && n < 10) begin tick(); n++; end
        checkOutput("tmo lb_rd seen", 32'(lbRd), 32'h1);
        checkOutput("tmo lb_addr", lbAddr, 32'hC);
        k = 0;
        while (!m1RdRdy && k < 30) begin tick(); k++; end
        checkOutput("tmo latency", 32'(k), 32'd9);
        checkOutput("tmo data", m1RdD, 32'hDEADBEEF);
        checkOutput("tmo m1_err", 32'(m1Err), 32'h1);
        checkOutput("tmo m0 untouched", 32'({m0Err, m0RdRdy}), 32'h0);
        tick();
        checkOutput("tmo pulse width", 32'(m1RdRdy), 32'h0);
        m0Wr = 1'b1; m0Addr = 32'h50; m0WrD = 32'h55;
        tick();
        m0Wr = 1'b0;
        n = 0;
        while (!lbWr && n < 10) begin tick(); n++; end
        checkOutput("post-tmo lb_wr", 32'(lbWr), 32'h1);
        checkOutput("post-tmo lb_addr", lbAddr, 32'h50);
        checkOutput("post-tmo lb_wr_d", lbWrD, 32'h55);
        tick();
        checkOutput("post-tmo m1_err sticky", 32'(m1Err), 32'h1);

        // Reset while a read waits for the slave.
        m0Rd = 1'b1; m0Addr = 32'h60;
        tick();
        m0Rd = 1'b0;
        n = 0;
        while (!lbRd && n < 10) begin tick(); n++; end
        checkOutput("rst-read lb_rd seen", 32'(lbRd), 32'h1);
        tick();
        tick();
        resetL = 1'b0;
        tick();
        checkOutput("rst-read status", 32'(status()), 32'h0);
        checkOutput("rst-read lb_addr", lbAddr, 32'h0);
        checkOutput("rst-read lb_wr_d", lbWrD, 32'h0);
        checkOutput("rst-read rd_d", m0RdD | m1RdD, 32'h0);
        resetL = 1'b1;
        tick();
        lbRdRdy = 1'b1; lbRdD = 32'h77777777;
        tick();
        lbRdRdy = 1'b0;
        checkOutput("stray rdy status", 32'(status()), 32'h0);
        checkOutput("stray rdy m0_rd_d", m0RdD, 32'h0);
        tick();
        checkOutput("stray rdy later", 32'(status()), 32'h0);

        // Fairness: both masters re-strobe writes one cycle after busy drops.
        grants = 0; cyc = 0; a0 = 0; a1 = 0;
        prevBusy0 = 1'b0; prevBusy1 = 1'b0;
        while (grants < 16 && cyc < 200) begin
            if (lbWr) begin
                checkOutput($sformatf("fair grant %0d", grants), 32'(lbAddr[13]), 32'(grants % 2));
                grants++;
            end
            wr0 = !m0Busy && !prevBusy0;
            wr1 = !m1Busy && !prevBusy1;
            prevBusy0 = m0Busy;
            prevBusy1 = m1Busy;
            m0Wr = wr0; m0Addr = 32'h1000 + 32'(a0); m0WrD = 32'hA000 + 32'(a0);
            m1Wr = wr1; m1Addr = 32'h2000 + 32'(a1); m1WrD = 32'hB000 + 32'(a1);
            if (wr0) a0++;
            if (wr1) a1++;
            tick();
            cyc++;
        end
        m0Wr = 1'b0; m1Wr = 1'b0;
        checkOutput("fair grant count", 32'(grants), 32'd16);
        checkOutput("fair no err", 32'({m1Err, m0Err}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lb_arb2.md
# lb_arb2

Two-master arbiter for the 32-bit local bus. It lets the Mesa-bus bridge (master 0) and an on-chip requester (master 1) share one `lb_*` slave port, for example a PROM boot sequencer or a self-test engine. Each master issues single-cycle write or read strobes with no backpressure. The block captures each strobe in a one-entry holding register, grants the bus round-robin, issues one transaction at a time, and returns read data, or a timeout word, to the master that issued the read.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `lb_rd_rdy` after `lb_rd` before aborting. Range 1..65535.
- `TIMEOUT_DATA`, default 32'hDEADBEEF: read data returned on timeout.
- `clk_lb`, in, 1: single clock; all logic rises on `posedge clk_lb`.
- `reset_l`, in, 1: synchronous, active-low reset.
- `m0_wr`, `m1_wr`, in, 1: single-cycle write strobe from master 0 or 1.
- `m0_rd`, `m1_rd`, in, 1: single-cycle read strobe from master 0 or 1.
- `m0_addr`, `m1_addr`, in, 32: address, sampled with the strobe.
- `m0_wr_d`, `m1_wr_d`, in, 32: write data, sampled with `mN_wr`.
- `m0_rd_d`, `m1_rd_d`, out, 32: read return data, valid with `mN_rd_rdy`.
- `m0_rd_rdy`, `m1_rd_rdy`, out, 1: one-cycle read-complete pulse.
- `m0_busy`, `m1_busy`, out, 1: high while that master has a held or in-flight transaction.
- `m0_err`, `m1_err`, out, 1: sticky flag for a dropped strobe or a read timeout. Cleared only by reset.
- `lb_wr`, `lb_rd`, out, 1: single-cycle strobes to the shared slave.
- `lb_addr`, `lb_wr_d`, out, 32: registered address and data to the slave.
- `lb_rd_d`, in, 32: slave read data.
- `lb_rd_rdy`, in, 1: slave read-data-valid pulse.

## Operation
- **Capture.** `mN_wr` or `mN_rd` while master N's holding slot is empty loads `{op, addr, wr_d}` and sets `pendN`.
  - If both `wr` and `rd` are high in the same cycle, the write is taken, the read is dropped and `mN_err` is set.
  - A strobe while `pendN` is set, or while master N's read is in flight, is dropped and sets `mN_err`.
- **`mN_busy`** = `pendN` OR (master N owns the current transaction).
- **FSM states:**
  - IDLE: if any `pend` is set, pick a winner. Winner's op is write → WR; winner's op is read → RD.
  - WR: `lb_wr`=1 for one cycle, clear the winner's `pend`, go to IDLE.
  - RD: `lb_rd`=1 for one cycle, clear `pend`, load the timeout counter with 0, go to RD_WAIT.
  - RD_WAIT: `lb_rd_rdy`=1 → set owner's `mN_rd_d`=`lb_rd_d` and pulse `mN_rd_rdy`, go to IDLE. Counter reaches `TIMEOUT` → set `mN_rd_d`=`TIMEOUT_DATA`, pulse `mN_rd_rdy`, set `mN_err`, go to IDLE.
- **Round-robin.** A `last` pointer records the last granted master. With both `pend` set, grant `~last`; with one set, grant it. `last` updates on every grant and resets to 1, so master 0 wins the first tie.
- **Stray `lb_rd_rdy`.** Ignored outside RD_WAIT. A late `rdy` that arrives during a later RD_WAIT is indistinguishable from a valid one; slaves must respond within `TIMEOUT` as a system requirement.
- **Counter width.** 16 bits, saturating, compared with `>=`.
- **Strobe during retire.** A new strobe from master N in the cycle its `pend` clears (WR or RD state) is accepted, because the slot is free at that edge.

## Timing
- **Reset.** While `reset_l`=0 at a clock edge, all outputs go to 0: strobes, `mN_rd_rdy`, `mN_busy`, `mN_err`, `lb_addr`, `lb_wr_d`, `mN_rd_d`. FSM goes to IDLE, `pend0`/`pend1` clear, `last`=1, counter=0.
- **Reset mid-read.** The read is abandoned silently: no `rd_rdy` pulse and no err.
- **Write latency.** Strobe in cycle T → `pend` set in T+1 → `lb_wr`/`lb_addr`/`lb_wr_d` valid in cycle T+2 when uncontended.
- **Back-to-back throughput.** One write per 2 cycles (IDLE, WR). Read throughput is bounded by slave latency + 2.
- **Read return.** `lb_rd_rdy` in cycle M → `mN_rd_rdy` and `mN_rd_d` valid in cycle M+1, for one cycle only.
- **Timeout.** With no `rdy`, the timeout `mN_rd_rdy` occurs `TIMEOUT`+1 cycles after the `lb_rd` cycle.
- **Output registering.** `lb_*` outputs are registered. `lb_addr` and `lb_wr_d` hold their last values between transactions.

## Test plan
- **Single write.** Reset; `m0_wr` with addr 0x00000010, data 0x12345678 at T → `lb_wr` pulse at T+2 with those values; `m0_busy` high for T+1..T+2 only.
- **Simultaneous reads.** `m0_rd` addr 0x4 and `m1_rd` addr 0x8 at the same cycle after reset; slave returns 0xA5A5A5A5 then 0x5A5A5A5A, 3 cycles after each `lb_rd` → first `lb_rd` has addr 0x4, second has addr 0x8. `m0_rd_rdy` carries 0xA5A5A5A5, `m1_rd_rdy` carries 0x5A5A5A5A, with no cross-delivery.
- **Fairness.** Both masters stream writes continuously, each re-strobing one cycle after its `busy` falls → `lb_wr` grants alternate 0,1,0,1 over 16 transactions.
- **Timeout.** `TIMEOUT`=8; `m1_rd` with a slave that never responds → `m1_rd_rdy` 9 cycles after `lb_rd`, with data 0xDEADBEEF; `m1_err`=1 and stays set; the next `m0_wr` proceeds normally.
- **Drop.** `m0_wr` twice in consecutive cycles → one `lb_wr` with the first address; `m0_err`=1. Separately, `m0_wr`+`m0_rd` in the same cycle → write issued, no `lb_rd`, `m0_err`=1.
- **Reset mid-read.** `reset_l` low during RD_WAIT → all outputs 0 next cycle; a `lb_rd_rdy` after reset produces no `mN_rd_rdy`.
